// File: rtl/sram_port_master.sv
// Request-stream initiator for one SRAM port; read data returns through a credited response FIFO.
// Optional post-reset array clear is compiled in with SRAM_PORT_MASTER_INIT_EN.

// fifo: generic first-in first-out buffer.
// Latency: data pushed in cycle T is visible at pop_dat in T+1.
// Backpressure: none internally; the producer must never push into a full FIFO unless popping.
module fifo #(
    parameter  int W     = 32,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic [W-1:0]  pop_dat,
    output logic          empty,
    output logic [CW-1:0] cnt
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          pop;
    logic          full;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign pop   = pop_rdy & ~empty;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_vld) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)      rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            cnt <= cnt + CW'(push_vld) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];

    no_overflow: assert property (@(posedge clk) disable iff (!arst_n) !(push_vld && full && !pop_rdy));
endmodule

// sram_port_master: converts req stream to SRAM en/wen/addr/din; init engine via SRAM_PORT_MASTER_INIT_EN.
// Latency: strobes combinational with request accept; read data on rsp 2 cycles after accept.
// Backpressure: writes never stall; reads stall when outstanding reads would exceed RSP_DEPTH.
module sram_port_master #(
    parameter  int           W          = 32,
    parameter  int           N          = 128,
    parameter  int           RSP_DEPTH  = 2,
    parameter  logic [W-1:0] INIT_VALUE = '0,
    localparam int           AW         = $clog2(N)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          req_vld,
    input  logic          req_wen,
    input  logic [AW-1:0] req_addr,
    input  logic [W-1:0]  req_wdata,
    output logic          req_rdy,
    output logic          rsp_vld,
    output logic [W-1:0]  rsp_rdata,
    input  logic          rsp_rdy,
    output logic          sram_en,
    output logic          sram_wen,
    output logic [AW-1:0] sram_addr,
    output logic [W-1:0]  sram_din,
    input  logic [W-1:0]  sram_dout,
    output logic          init_done
);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic          active_r;
    logic          run;
    logic          init_wr;
    logic [AW-1:0] init_addr;
    logic          rd_pend_r;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty;
    logic          credit;
    logic          acc;

    // Holds every strobe low through the reset-release cycle.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) active_r <= 1'b0;
        else         active_r <= 1'b1;
    end

`ifdef SRAM_PORT_MASTER_INIT_EN
    typedef enum logic {INIT, RUN} state_t;
    state_t        state_r;
    state_t        state_nxt;
    logic [AW-1:0] init_addr_r;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r     <= INIT;
            init_addr_r <= '0;
        end else begin
            state_r <= state_nxt;
            if (init_wr) init_addr_r <= init_addr_r + AW'(1);
        end
    end

    always_comb begin
        state_nxt = state_r;
        init_wr   = 1'b0;
        case (state_r)
            INIT: begin
                init_wr = active_r;
                if (active_r && init_addr_r == AW'(N - 1)) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign init_addr = init_addr_r;
    assign run       = (state_r == RUN);
`else
    assign init_wr   = 1'b0;
    assign init_addr = '0;
    assign run       = active_r;
`endif

    assign init_done = run;
    assign credit    = (int'(fifo_cnt) + int'(rd_pend_r)) < RSP_DEPTH;
    assign req_rdy   = run & (req_wen | credit);
    assign acc       = req_vld & req_rdy;

    always_comb begin
        sram_en   = 1'b0;
        sram_wen  = 1'b0;
        sram_addr = '0;
        sram_din  = '0;
        if (init_wr) begin
            sram_en   = 1'b1;
            sram_wen  = 1'b1;
            sram_addr = init_addr;
            sram_din  = INIT_VALUE;
        end else if (acc) begin
            sram_en   = 1'b1;
            sram_wen  = req_wen;
            sram_addr = req_addr;
            sram_din  = req_wdata;
        end
    end

    // Read issued last cycle: the SRAM output register holds its data now.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) rd_pend_r <= 1'b0;
        else         rd_pend_r <= acc & ~req_wen;
    end

    fifo #(.W(W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk      (clk),
        .arst_n   (arst_n),
        .push_vld (rd_pend_r),
        .push_dat (sram_dout),
        .pop_rdy  (rsp_rdy),
        .pop_dat  (rsp_rdata),
        .empty    (fifo_empty),
        .cnt      (fifo_cnt)
    );

    assign rsp_vld = ~fifo_empty;
endmodule

// File: tb/tb_sram_port_master.sv
// Scoreboard bench for sram_port_master with a behavioural registered-output SRAM.
// Expected read data comes from a shadow array updated as requests are accepted.
module tb_sram_port_master;
    localparam int           W  = 32;
    localparam int           N  = 128;
    localparam int           RD = 3;
    localparam int           AW = $clog2(N);
    localparam logic [W-1:0] IV = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          req_vld;
    logic          req_wen;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  req_wdata;
    logic          req_rdy;
    logic          rsp_vld;
    logic [W-1:0]  rsp_rdata;
    logic          rsp_rdy;
    logic          sram_en;
    logic          sram_wen;
    logic [AW-1:0] sram_addr;
    logic [W-1:0]  sram_din;
    logic [W-1:0]  sram_dout;
    logic          init_done;

    always #5 clk = ~clk;

    sram_port_master #(.W(W), .N(N), .RSP_DEPTH(RD), .INIT_VALUE(IV)) dut (
        .clk(clk), .arst_n(arst_n),
        .req_vld(req_vld), .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata), .req_rdy(req_rdy),
        .rsp_vld(rsp_vld), .rsp_rdata(rsp_rdata), .rsp_rdy(rsp_rdy),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_din(sram_din),
        .sram_dout(sram_dout), .init_done(init_done)
    );

    logic [W-1:0] mem [N];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wen) mem[sram_addr] <= sram_din;
            else          sram_dout      <= mem[sram_addr];
        end
    end

    logic [W-1:0] shadow [N];
    logic [W-1:0] exp_q [$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  rsp_cnt, rsp_first, rsp_last;
    bit  last_acc;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called just after the falling edge settles; books the cycle, then waits for the next falling edge.
    task automatic adv();
        last_acc = req_vld && req_rdy;
        if (last_acc && !req_wen) exp_q.push_back(shadow[req_addr]);
        if (last_acc && req_wen)  shadow[req_addr] = req_wdata;
        if (rsp_vld && rsp_rdy) begin
            if (exp_q.size() == 0) check("rsp_spurious", rsp_vld, 1'b0);
            else                   check("rsp_data", rsp_rdata, exp_q.pop_front());
            if (rsp_cnt == 0) rsp_first = cyc;
            rsp_last = cyc;
            rsp_cnt++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic tick();
        #1;
        adv();
    endtask

    task automatic req(input logic wen, input logic [AW-1:0] a, input logic [W-1:0] d);
        int k = 0;
        req_vld = 1'b1; req_wen = wen; req_addr = a; req_wdata = d;
        do begin
            tick();
            k++;
        end while (!last_acc && k < 100);
        check("req_accept", last_acc, 1'b1);
        req_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drain();
        int k = 0;
        rsp_rdy = 1'b1;
        while (exp_q.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic check_rst(input string tag);
        check({tag, "_req_rdy"},   req_rdy,   1'b0);
        check({tag, "_rsp_vld"},   rsp_vld,   1'b0);
        check({tag, "_sram_en"},   sram_en,   1'b0);
        check({tag, "_sram_wen"},  sram_wen,  1'b0);
        check({tag, "_sram_addr"}, sram_addr, '0);
        check({tag, "_sram_din"},  sram_din,  '0);
        check({tag, "_init_done"}, init_done, 1'b0);
    endtask

`ifdef SRAM_PORT_MASTER_INIT_EN
    // Entered one falling edge after reset release; a write request is held up the whole time.
    task automatic init_phase(input string tag);
        int wr = 0;
        int bad = 0;
        int k;
        req_vld = 1'b1; req_wen = 1'b1; req_addr = '0; req_wdata = '0;
        for (k = 0; k < N + 20; k++) begin
            #1;
            if (init_done) break;
            if (sram_en && sram_wen && sram_addr == AW'(wr) && sram_din == IV) wr++;
            else bad++;
            if (req_rdy || rsp_vld) bad++;
            @(negedge clk);
        end
        req_vld = 1'b0;
        check({tag, "_writes"}, wr, N);
        check({tag, "_cycles"}, k, N);
        check({tag, "_bad"}, bad, 0);
        @(negedge clk);
        for (int i = 0; i < N; i++) shadow[i] = IV;
    endtask
`endif

    initial begin
        int nacc, stalls;
        for (int i = 0; i < N; i++) mem[i] = '0;
        arst_n = 1'b0; req_vld = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; rsp_rdy = 1'b0;
        rsp_cnt = 0; rsp_first = 0; rsp_last = 0;
        repeat (2) @(negedge clk);
        req_vld = 1'b1; req_wen = 1'b1;
        #1;
        check_rst("rst");
        req_vld = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

`ifdef SRAM_PORT_MASTER_INIT_EN
        init_phase("init");
        req(1'b0, 7'd0, '0);
        req(1'b0, 7'd64, '0);
        req(1'b0, 7'd127, '0);
        drain();
`else
        #1;
        check("init_done_up", init_done, 1'b1);
        @(negedge clk);
`endif

        // Write then read same address on consecutive cycles; response two cycles after the read.
        rsp_rdy = 1'b0;
        req(1'b1, 7'd5, 32'h1234_5678);
        req(1'b0, 7'd5, '0);
        #1;
        check("lat_t2_vld", rsp_vld, 1'b0);
        @(negedge clk);
        #1;
        check("lat_t3_vld", rsp_vld, 1'b1);
        check("lat_t3_data", rsp_rdata, 32'h1234_5678);
        @(negedge clk);
        #1;
        check("hold_data", rsp_rdata, 32'h1234_5678);
        @(negedge clk);
        drain();

        // Credit limit with responses blocked.
        for (int i = 1; i <= 4; i++) req(1'b1, AW'(i), W'(i));
        rsp_rdy = 1'b0;
        nacc = 0;
        for (int i = 0; i < 8; i++) begin
            req_vld = (nacc < 4); req_wen = 1'b0; req_addr = AW'(nacc + 1);
            tick();
            if (last_acc) nacc++;
        end
        check("credit_reads", nacc, RD);
        req_vld = 1'b1; req_wen = 1'b0; req_addr = 7'd4;
        #1;
        check("rd_stall", req_rdy, 1'b0);
        req_wen = 1'b1; req_addr = 7'd100; req_wdata = 32'h77;
        #1;
        check("wr_no_stall", req_rdy, 1'b1);
        adv();
        #1;
        check("stall_hold", rsp_rdata, exp_q[0]);
        req_vld = 1'b1; req_wen = 1'b0; req_addr = 7'd4; rsp_rdy = 1'b1;
        #1;
        check("credit_same_cycle", req_rdy, 1'b0);
        adv();
        rsp_rdy = 1'b0;
        #1;
        check("credit_restored", req_rdy, 1'b1);
        adv();
        req_vld = 1'b0;
        drain();

        // Back-to-back reads, responses consumed every cycle.
        for (int i = 0; i < 10; i++) req(1'b1, AW'(20 + i), 32'h100 + W'(i));
        rsp_rdy = 1'b1; rsp_cnt = 0; stalls = 0; nacc = 0;
        for (int k = 0; k < 40 && nacc < 10; k++) begin
            req_vld = 1'b1; req_wen = 1'b0; req_addr = AW'(20 + nacc);
            tick();
            if (last_acc) nacc++;
            else stalls++;
        end
        req_vld = 1'b0;
        drain();
        check("b2b_stalls", stalls, 0);
        check("b2b_count", rsp_cnt, 10);
        check("b2b_span", rsp_last - rsp_first + 1, 10);

        // Read followed by write to the same address returns the old word.
        req(1'b1, 7'd9, 32'hA);
        idle(2);
        req(1'b0, 7'd9, '0);
        req(1'b1, 7'd9, 32'hB);
        drain();
        req(1'b0, 7'd9, '0);
        drain();

        // Reset with two reads in flight.
        rsp_rdy = 1'b0;
        req(1'b0, 7'd9, '0);
        req(1'b0, 7'd5, '0);
        req_vld = 1'b1; req_wen = 1'b1;
        arst_n = 1'b0;
        #1;
        check_rst("mid_rst");
        req_vld = 1'b0;
        exp_q.delete();
        rsp_rdy = 1'b1;
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
`ifdef SRAM_PORT_MASTER_INIT_EN
        init_phase("reinit");
`else
        #1;
        check("rerun_done", init_done, 1'b1);
        check("rerun_stale", rsp_vld, 1'b0);
        @(negedge clk);
`endif
        rsp_cnt = 0;
        idle(4);
        check("no_stale_rsp", rsp_cnt, 0);
        req(1'b0, 7'd5, '0);
        drain();
        check("init_done_hold", init_done, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
